// File: rtl/sprite_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sprite_ctrl_pkg
// Shared definitions for the sprite motion controller:
//   - CPU field codes for wr_field
//   - update FSM state encoding
//   - default coordinate/velocity widths
//   - helpers deriving the home position and the travel limit of a sprite
// -----------------------------------------------------------------------------
package sprite_ctrl_pkg;

    localparam int CORDW_DEF = 16;
    localparam int VELW_DEF  = 8;

    localparam logic [1:0] FLD_X  = 2'd0;
    localparam logic [1:0] FLD_Y  = 2'd1;
    localparam logic [1:0] FLD_VX = 2'd2;
    localparam logic [1:0] FLD_VY = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPD_X  = 2'd1,
        ST_UPD_Y  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Centred position: sprite drawn in the middle of the active area.
    function automatic int spr_home(input int res, input int draw);
        return res / 2 - draw / 2;
    endfunction

    // Largest top-left coordinate that keeps the whole sprite on screen.
    function automatic int spr_limit(input int res, input int draw);
        return res - draw;
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// -----------------------------------------------------------------------------
// sprite_axis_step
// Combinational step for one axis of one sprite: advance pos by vel and, when
// the result leaves [0, pos_max], clamp to the edge and reflect the velocity.
// Ports:
//   pos      in  CORDW  current position (signed)
//   vel      in  VELW   current velocity (signed, pixels/frame)
//   pos_max  in  CORDW  upper bound for this axis (non-negative)
//   nxt_pos  out CORDW  stepped position
//   nxt_vel  out VELW   stepped velocity
// -----------------------------------------------------------------------------
module sprite_axis_step
    import sprite_ctrl_pkg::*;
#(
    parameter int CORDW = CORDW_DEF,
    parameter int VELW  = VELW_DEF
) (
    input  logic [CORDW-1:0] pos,
    input  logic [VELW-1:0]  vel,
    input  logic [CORDW-1:0] pos_max,
    output logic [CORDW-1:0] nxt_pos,
    output logic [VELW-1:0]  nxt_vel
);

    // One extra bit so that pos+vel cannot wrap before the bound checks.
    logic signed [CORDW:0] sum;
    logic signed [CORDW:0] lim;
    logic [VELW-1:0]       vel_neg;

    assign sum = $signed({pos[CORDW-1], pos})
               + $signed({{(CORDW+1-VELW){vel[VELW-1]}}, vel});
    assign lim = $signed({1'b0, pos_max});

    // Negating the most negative velocity would overflow; saturate instead.
    assign vel_neg = (vel == {1'b1, {(VELW-1){1'b0}}}) ? {1'b0, {(VELW-1){1'b1}}}
                                                       : (~vel + 1'b1);

    always_comb begin
        nxt_pos = sum[CORDW-1:0];
        nxt_vel = vel;
        if (sum < 0) begin
            nxt_pos = '0;
            nxt_vel = vel_neg;
        end else if (sum > lim) begin
            nxt_pos = pos_max;
            nxt_vel = vel_neg;
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_motion_ctrl
// Per-frame motion scheduler for NUM_SPR sprites. Each frame pulse starts a
// fixed-length pass that steps every sprite (X then Y) through one shared
// sprite_axis_step unit, then copies all working positions to the output
// shadow registers in a single cycle so renderers never see a partial update.
// Ports:
//   clk_25MHz  in   pixel clock
//   btn_rst_n  in   synchronous active-low reset
//   frame      in   start-of-frame pulse
//   spr_en     in   per-sprite motion enable
//   wr_en      in   CPU field write strobe
//   wr_idx     in   target sprite (indices >= NUM_SPR ignored)
//   wr_field   in   0=x 1=y 2=vx 3=vy
//   wr_data    in   write data (velocities use the low VELW bits)
//   spr_x/y    out  committed positions, sprite i at [i*CORDW +: CORDW]
//   busy       out  pass in progress
//   done       out  one-cycle pulse, first cycle new positions are visible
//   overrun    out  one-cycle pulse, frame arrived while busy (ignored)
// -----------------------------------------------------------------------------
module sprite_motion_ctrl
    import sprite_ctrl_pkg::*;
#(
    parameter  int NUM_SPR   = 4,
    parameter  int CORDW     = CORDW_DEF,
    parameter  int VELW      = VELW_DEF,
    parameter  int H_RES     = 640,
    parameter  int V_RES     = 480,
    parameter  int SPR_DRAWW = 64,
    parameter  int SPR_DRAWH = 64,
    localparam int IDXW      = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic                     clk_25MHz,
    input  logic                     btn_rst_n,
    input  logic                     frame,
    input  logic [NUM_SPR-1:0]       spr_en,
    input  logic                     wr_en,
    input  logic [IDXW-1:0]          wr_idx,
    input  logic [1:0]               wr_field,
    input  logic [CORDW-1:0]         wr_data,
    output logic [NUM_SPR*CORDW-1:0] spr_x,
    output logic [NUM_SPR*CORDW-1:0] spr_y,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam logic [CORDW-1:0] X_HOME   = CORDW'(spr_home(H_RES, SPR_DRAWW));
    localparam logic [CORDW-1:0] Y_HOME   = CORDW'(spr_home(V_RES, SPR_DRAWH));
    localparam logic [CORDW-1:0] X_MAX    = CORDW'(spr_limit(H_RES, SPR_DRAWW));
    localparam logic [CORDW-1:0] Y_MAX    = CORDW'(spr_limit(V_RES, SPR_DRAWH));
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NUM_SPR - 1);

    state_t          state_reg, state_next;
    logic [IDXW-1:0] idx_reg, idx_next;
    logic            done_reg, done_next;
    logic            overrun_reg, overrun_next;

    // Working registers flattened so the shared unit can select by idx.
    logic [NUM_SPR*CORDW-1:0] x_cur, y_cur;
    logic [NUM_SPR*VELW-1:0]  vx_cur, vy_cur;

    logic [CORDW-1:0] step_pos, step_max, step_nxt_pos;
    logic [VELW-1:0]  step_vel, step_nxt_vel;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_25MHz) begin
        if (!btn_rst_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        done_next    = 1'b0;
        overrun_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (frame) begin
                    state_next = ST_UPD_X;
                    idx_next   = '0;
                end
            end
            ST_UPD_X: state_next = ST_UPD_Y;
            ST_UPD_Y: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_COMMIT;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = ST_UPD_X;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
        // A frame during any non-idle cycle is dropped, only flagged.
        if (frame && state_reg != ST_IDLE) begin
            overrun_next = 1'b1;
        end
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign overrun = overrun_reg;

    // ---------------- shared step unit ----------------
    always_comb begin
        step_pos = x_cur[idx_reg*CORDW +: CORDW];
        step_vel = vx_cur[idx_reg*VELW +: VELW];
        step_max = X_MAX;
        if (state_reg == ST_UPD_Y) begin
            step_pos = y_cur[idx_reg*CORDW +: CORDW];
            step_vel = vy_cur[idx_reg*VELW +: VELW];
            step_max = Y_MAX;
        end
    end

    sprite_axis_step #(
        .CORDW (CORDW),
        .VELW  (VELW)
    ) u_step (
        .pos     (step_pos),
        .vel     (step_vel),
        .pos_max (step_max),
        .nxt_pos (step_nxt_pos),
        .nxt_vel (step_nxt_vel)
    );

    // ---------------- per-sprite registers ----------------
    for (genvar gi = 0; gi < NUM_SPR; gi++) begin : gen_spr
        logic [CORDW-1:0] x_reg, x_next, y_reg, y_next;
        logic [VELW-1:0]  vx_reg, vx_next, vy_reg, vy_next;
        logic [CORDW-1:0] out_x_reg, out_y_reg;
        logic             step_x, step_y, wr_hit;

        assign step_x = (state_reg == ST_UPD_X) && (idx_reg == IDXW'(gi)) && spr_en[gi];
        assign step_y = (state_reg == ST_UPD_Y) && (idx_reg == IDXW'(gi)) && spr_en[gi];
        assign wr_hit = wr_en && (wr_idx == IDXW'(gi));

        always_comb begin
            x_next  = x_reg;
            y_next  = y_reg;
            vx_next = vx_reg;
            vy_next = vy_reg;
            if (step_x) begin
                x_next  = step_nxt_pos;
                vx_next = step_nxt_vel;
            end
            if (step_y) begin
                y_next  = step_nxt_pos;
                vy_next = step_nxt_vel;
            end
            // CPU write overrides only the field it targets; the step result
            // for the sibling field of the same axis still lands.
            if (wr_hit) begin
                case (wr_field)
                    FLD_X:   x_next  = wr_data;
                    FLD_Y:   y_next  = wr_data;
                    FLD_VX:  vx_next = wr_data[VELW-1:0];
                    default: vy_next = wr_data[VELW-1:0];
                endcase
            end
        end

        always_ff @(posedge clk_25MHz) begin
            if (!btn_rst_n) begin
                x_reg     <= X_HOME;
                y_reg     <= Y_HOME;
                vx_reg    <= '0;
                vy_reg    <= '0;
                out_x_reg <= X_HOME;
                out_y_reg <= Y_HOME;
            end else begin
                x_reg  <= x_next;
                y_reg  <= y_next;
                vx_reg <= vx_next;
                vy_reg <= vy_next;
                if (state_reg == ST_COMMIT) begin
                    out_x_reg <= x_reg;
                    out_y_reg <= y_reg;
                end
            end
        end

        assign x_cur[gi*CORDW +: CORDW] = x_reg;
        assign y_cur[gi*CORDW +: CORDW] = y_reg;
        assign vx_cur[gi*VELW +: VELW]  = vx_reg;
        assign vy_cur[gi*VELW +: VELW]  = vy_reg;
        assign spr_x[gi*CORDW +: CORDW] = out_x_reg;
        assign spr_y[gi*CORDW +: CORDW] = out_y_reg;
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_ctrl
// Directed stimulus with hand-computed positions. Expected committed position
// sets are queued before each frame; a monitor pops and compares one set on
// every done pulse and also checks pass length and done latency.
// -----------------------------------------------------------------------------
module tb_sprite_motion_ctrl;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int VW = 8;

    logic            clk_25MHz = 1'b0;
    logic            btn_rst_n;
    logic            frame;
    logic [N-1:0]    spr_en;
    logic            wr_en;
    logic [1:0]      wr_idx;
    logic [1:0]      wr_field;
    logic [CW-1:0]   wr_data;
    logic [N*CW-1:0] spr_x, spr_y;
    logic            busy, done, overrun;

    always #20 clk_25MHz = ~clk_25MHz;

    sprite_motion_ctrl #(
        .NUM_SPR(N), .CORDW(CW), .VELW(VW),
        .H_RES(640), .V_RES(480), .SPR_DRAWW(64), .SPR_DRAWH(64)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .btn_rst_n (btn_rst_n),
        .frame     (frame),
        .spr_en    (spr_en),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .spr_x     (spr_x),
        .spr_y     (spr_y),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    typedef struct {
        logic [N*CW-1:0] x;
        logic [N*CW-1:0] y;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   ex[N];
    int   ey[N];
    int   done_cnt = 0;
    int   ovr_cnt = 0;
    int   negcnt = 0;
    int   busy_start = 0;
    int   busy_len = 0;
    logic busy_prev = 1'b0;
    int   ovr_before, dc_before;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: one comparison set per done pulse.
    always @(negedge clk_25MHz) begin
        negcnt++;
        if (busy && !busy_prev) begin
            busy_start = negcnt;
            busy_len   = 0;
        end
        if (busy) busy_len++;
        busy_prev = busy;
        if (overrun) ovr_cnt++;
        if (done) begin
            done_cnt++;
            chk("busy_len", busy_len, 9);
            chk("done_latency", negcnt - busy_start, 9);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no pending commit");
            end else begin
                mon_e = exp_q.pop_front();
                $display("commit %0d: x=%h y=%h", done_cnt, spr_x, spr_y);
                for (int i = 0; i < N; i++) begin
                    chk($sformatf("spr_x[%0d]", i), 32'(spr_x[i*CW +: CW]), 32'(mon_e.x[i*CW +: CW]));
                    chk($sformatf("spr_y[%0d]", i), 32'(spr_y[i*CW +: CW]), 32'(mon_e.y[i*CW +: CW]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic wr(input int idx, input logic [1:0] f, input logic [CW-1:0] d);
        wr_en    = 1'b1;
        wr_idx   = idx[1:0];
        wr_field = f;
        wr_data  = d;
        tick();
        wr_en    = 1'b0;
        $display("write spr %0d field %0d data %0d", idx, f, d);
    endtask

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.x[i*CW +: CW] = CW'(ex[i]);
            e.y[i*CW +: CW] = CW'(ey[i]);
        end
        exp_q.push_back(e);
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic wait_commit();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL commit_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
    endtask

    task automatic check_home(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, $sformatf("_x[%0d]", i)}, 32'(spr_x[i*CW +: CW]), 288);
            chk({tag, $sformatf("_y[%0d]", i)}, 32'(spr_y[i*CW +: CW]), 208);
        end
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        $display("%s: home positions x=%h y=%h", tag, spr_x, spr_y);
    endtask

    initial begin
        btn_rst_n = 1'b0;
        frame     = 1'b0;
        spr_en    = '0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_field  = '0;
        wr_data   = '0;
        for (int i = 0; i < N; i++) begin
            ex[i] = 288;
            ey[i] = 208;
        end

        // 1. reset
        tick();
        tick();
        btn_rst_n = 1'b1;
        tick();
        check_home("reset");

        // 2. basic step
        wr(0, 2'd2, 16'd4);
        spr_en = 4'b0001;
        ex[0] = 292; push_exp(); frame_pulse(); wait_commit();

        // 3. reflection at max, then moving back
        wr(1, 2'd0, 16'd574);
        wr(1, 2'd2, 16'd4);
        spr_en = 4'b0010;
        ex[1] = 576; push_exp(); frame_pulse(); wait_commit();
        ex[1] = 572; push_exp(); frame_pulse(); wait_commit();

        // 4. reflection at min on Y
        wr(2, 2'd1, 16'd2);
        wr(2, 2'd3, 16'hFFFB);
        spr_en = 4'b0100;
        ey[2] = 0; push_exp(); frame_pulse(); wait_commit();
        ey[2] = 5; push_exp(); frame_pulse(); wait_commit();

        // 4b. -128 velocity reflects to +127
        wr(3, 2'd0, 16'd0);
        wr(3, 2'd2, 16'hFF80);
        spr_en = 4'b1000;
        ex[3] = 0;   push_exp(); frame_pulse(); wait_commit();
        ex[3] = 127; push_exp(); frame_pulse(); wait_commit();

        // 5. frame while busy
        ovr_before = ovr_cnt;
        dc_before  = done_cnt;
        ex[3] = 254; push_exp();
        frame_pulse();
        tick();
        tick();
        frame_pulse();
        wait_commit();
        repeat (12) tick();
        chk("overrun_pulses", ovr_cnt - ovr_before, 1);
        chk("done_pulses", done_cnt - dc_before, 1);

        // 6. CPU write collides with the X step of sprite 0
        spr_en = 4'b0001;
        ex[0] = 100; push_exp();
        frame_pulse();
        wr(0, 2'd0, 16'd100);
        wait_commit();
        ex[0] = 104; push_exp(); frame_pulse(); wait_commit();

        // 6b. reset mid-pass
        dc_before = done_cnt;
        frame_pulse();
        tick();
        tick();
        tick();
        btn_rst_n = 1'b0;
        tick();
        btn_rst_n = 1'b1;
        check_home("midreset");
        repeat (15) tick();
        chk("done_after_reset", done_cnt - dc_before, 0);

        // velocities were cleared by reset: an all-enabled pass stays home
        for (int i = 0; i < N; i++) begin
            ex[i] = 288;
            ey[i] = 208;
        end
        spr_en = 4'b1111;
        push_exp(); frame_pulse(); wait_commit();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Per-frame motion scheduler for up to NUM_SPR hardware sprites driving the sprite pixel datapath.
- Holds working position and velocity registers per sprite; accepts CPU-side field writes.
- On each frame pulse, steps every sprite through one shared add/bounce unit, X then Y.
- Commits all new positions atomically to output shadow registers, so the sprite renderers never see a half-updated set.
- Sits between the VGA timing block (frame pulse) and the sprite instances (sprx/spry inputs), in the 25 MHz pixel domain.

Parameters:
- NUM_SPR, 4, number of sprites (≥1).
- CORDW, 16, signed coordinate width.
- VELW, 8, signed velocity width (pixels/frame).
- H_RES, 640, active width.
- V_RES, 480, active height.
- SPR_DRAWW, 64, drawn sprite width.
- SPR_DRAWH, 64, drawn sprite height.

Ports:
- clk_25MHz  in  1  pixel clock; only clock.
- btn_rst_n  in  1  reset, synchronous, active-low.
- frame  in  1  one-cycle start-of-frame pulse from timing block.
- spr_en  in  NUM_SPR  per-sprite motion enable.
- wr_en  in  1  CPU field write strobe.
- wr_idx  in  clog2(NUM_SPR) (min 1)  target sprite.
- wr_field  in  2  0=x, 1=y, 2=vx, 3=vy.
- wr_data  in  CORDW  write data; vx/vy take low VELW bits.
- spr_x  out  NUM_SPR*CORDW  committed X, sprite i at bits [i*CORDW +: CORDW].
- spr_y  out  NUM_SPR*CORDW  committed Y, same packing.
- busy  out  1  update pass in progress.
- done  out  1  one-cycle pulse, commit complete.
- overrun  out  1  one-cycle pulse, frame arrived while busy.

Behaviour:
- Reset (btn_rst_n=0 at clock edge):
  - all working and committed x = H_RES/2-SPR_DRAWW/2 (288); y = V_RES/2-SPR_DRAWH/2 (208).
  - all vx = vy = 0.
  - state IDLE; busy, done, overrun = 0.
  - Reset mid-pass aborts the pass: no commit, no done.
- FSM states: IDLE, UPD_X, UPD_Y, COMMIT. Sprite index idx is 0..NUM_SPR-1.
  - IDLE: frame=1 -> UPD_X with idx=0; busy=1 from the next cycle.
  - UPD_X: step x[idx]/vx[idx] -> UPD_Y.
  - UPD_Y: step y[idx]/vy[idx]. If idx=NUM_SPR-1 -> COMMIT, else idx+1 -> UPD_X.
  - COMMIT: copy all working x/y to spr_x/spr_y -> IDLE.
- Latency:
  - Pass length is fixed at 2*NUM_SPR+1 cycles (busy high for exactly these cycles).
  - done is registered high for one cycle, the first cycle new outputs are visible: 2*NUM_SPR+1 cycles after the frame-sampling edge.
  - busy falls in that same cycle.
- Step rule for one axis, shared unit:
  - nxt = pos + sign_extend(vel), computed at CORDW+1 bits.
  - Bounds: min=0; max=H_RES-SPR_DRAWW (X, 576) or V_RES-SPR_DRAWH (Y, 416).
  - nxt<min: pos=min, vel=-vel.
  - nxt>max: pos=max, vel=-vel.
  - Otherwise pos=nxt, vel unchanged.
  - Negating the most negative vel (-128) saturates to +127.
  - Out-of-range positions written by CPU are clamped by the same rule at the next step.
- Disabled sprite (spr_en[idx]=0 when its step is evaluated): pos/vel held. Its cycles are still consumed, so latency stays fixed.
- CPU writes:
  - Accepted every cycle, including while busy; land in working registers next edge.
  - Reach outputs only at the next COMMIT.
  - A write to the same field being stepped in that cycle wins over the step result. The other field of that step (pos vs vel) still updates.
  - wr_idx ≥ NUM_SPR is ignored.
- frame while busy (including the COMMIT cycle): ignored. overrun pulses for one cycle; the current pass is unaffected.
- Outputs spr_x/spr_y change only at reset or COMMIT.

Decomposition:
- Package sprite_ctrl_pkg:
  - field codes FLD_X/FLD_Y/FLD_VX/FLD_VY.
  - FSM state encoding.
  - default CORDW/VELW.
  - bound helper constants.
- One sub-module, sprite_axis_step: combinational clamp/reflect unit.
  - Inputs: pos, vel, max.
  - Outputs: nxt_pos, nxt_vel.
  - Instantiated once and time-shared across axes and sprites.

Test Plan:
1. Reset held 2 cycles, release -> every spr_x lane = 288, spr_y lane = 208; busy=done=overrun=0.
2. Write vx[0]=4, spr_en=4'b0001, pulse frame -> done exactly 9 cycles later; spr_x[0]=292; other lanes unchanged; busy high 9 cycles.
3. Reflection at max:
   - Write x[1]=574, vx[1]=4, enable sprite 1, frame -> spr_x[1]=576, vx[1]=-4.
   - Next frame -> 572.
4. Reflection at min:
   - Write y[2]=2, vy[2]=-5, frame -> spr_y[2]=0.
   - Next frame -> 5.
   - Separately, x=0, vx=-128 -> x=0, vx=+127.
5. Pulse frame, then frame again 3 cycles later -> overrun one-cycle pulse; only one done; positions advanced once.
6. Collision and reset:
   - Write x[0]=100 in sprite 0's UPD_X cycle -> committed spr_x[0]=100.
   - Assert btn_rst_n=0 mid-pass -> outputs return to 288/208; no done.
